// File: rtl/cordic_pipe_arbiter_if.sv
// Request, core-side and response bundle for cordic_pipe_arbiter.
// The arbiter uses the slave view; the surrounding environment uses the master view.
interface cordic_pipe_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  // Requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic [WIDTH-1:0] req0_z;
  logic             req0_mode;
  // Requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic [WIDTH-1:0] req1_z;
  logic             req1_mode;
  // Shared CORDIC core
  logic             c_valid_in;
  logic [WIDTH-1:0] c_x;
  logic [WIDTH-1:0] c_y;
  logic [WIDTH-1:0] c_z;
  logic             c_mode;
  logic             c_valid_out;
  logic [WIDTH-1:0] c_cos;
  logic [WIDTH-1:0] c_sin;
  // Tagged result
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_cos;
  logic [WIDTH-1:0] rsp_sin;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_z, req0_mode,
    input  req1_valid, req1_x, req1_y, req1_z, req1_mode,
    input  c_valid_out, c_cos, c_sin,
    output req0_ready, req1_ready,
    output c_valid_in, c_x, c_y, c_z, c_mode,
    output rsp_valid, rsp_id, rsp_cos, rsp_sin
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_z, req0_mode,
    output req1_valid, req1_x, req1_y, req1_z, req1_mode,
    output c_valid_out, c_cos, c_sin,
    input  req0_ready, req1_ready,
    input  c_valid_in, c_x, c_y, c_z, c_mode,
    input  rsp_valid, rsp_id, rsp_cos, rsp_sin
  );
endinterface

// File: rtl/cordic_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency CORDIC pipeline between two requesters,
// with a shadow tag pipe that routes results back and flags core valid misalignment.
module cordic_pipe_arbiter #(
  parameter  int unsigned NUM_STAGES = 12,
  parameter  int unsigned WIDTH      = 16,
  localparam int unsigned CNT_W      = $clog2(NUM_STAGES + 2) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  cordic_pipe_arbiter_if.slave bus,
  output logic [CNT_W-1:0]     inflight,
  output logic                 seq_err
);

  // Arbitration state: last requester that was accepted
  logic last_grant_q, last_grant_d;

  // Issue registers toward the core
  logic             c_valid_q, c_valid_d;
  logic             c_id_q,    c_id_d;
  logic [WIDTH-1:0] c_x_q,     c_x_d;
  logic [WIDTH-1:0] c_y_q,     c_y_d;
  logic [WIDTH-1:0] c_z_q,     c_z_d;
  logic             c_mode_q,  c_mode_d;

  // Shadow tag pipe, tail aligned with the core's valid_out
  logic [NUM_STAGES-1:0] tag_v_q,  tag_v_d;
  logic [NUM_STAGES-1:0] tag_id_q, tag_id_d;

  // Response and bookkeeping registers
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_cos_q,   rsp_cos_d;
  logic [WIDTH-1:0] rsp_sin_q,   rsp_sin_d;
  logic [CNT_W-1:0] inflight_q,  inflight_d;
  logic             seq_err_q,   seq_err_d;

  logic gnt0_c, gnt1_c, accept_c, accept_id_c;
  logic tail_v_c, tail_id_c, rsp_fire_c, mismatch_c;

  // Round-robin grant; a tie goes to the requester that did not win last
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (en) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0_c = last_grant_q;
        gnt1_c = !last_grant_q;
      end else begin
        gnt0_c = bus.req0_valid;
        gnt1_c = bus.req1_valid;
      end
    end
  end

  assign accept_c    = gnt0_c | gnt1_c;
  assign accept_id_c = gnt1_c;

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;

  // Operand capture; operands hold when nothing is issued
  always_comb begin
    last_grant_d = last_grant_q;
    c_valid_d    = accept_c;
    c_id_d       = c_id_q;
    c_x_d        = c_x_q;
    c_y_d        = c_y_q;
    c_z_d        = c_z_q;
    c_mode_d     = c_mode_q;
    if (accept_c) begin
      last_grant_d = accept_id_c;
      c_id_d       = accept_id_c;
      if (accept_id_c) begin
        c_x_d    = bus.req1_x;
        c_y_d    = bus.req1_y;
        c_z_d    = bus.req1_z;
        c_mode_d = bus.req1_mode;
      end else begin
        c_x_d    = bus.req0_x;
        c_y_d    = bus.req0_y;
        c_z_d    = bus.req0_z;
        c_mode_d = bus.req0_mode;
      end
    end
  end

  assign tail_v_c   = tag_v_q[NUM_STAGES-1];
  assign tail_id_c  = tag_id_q[NUM_STAGES-1];
  assign rsp_fire_c = tail_v_c & bus.c_valid_out;
  assign mismatch_c = tail_v_c ^ bus.c_valid_out;

  // Tag shift, response capture, error flag and occupancy tracking
  always_comb begin
    tag_v_d     = {tag_v_q[NUM_STAGES-2:0],  c_valid_q};
    tag_id_d    = {tag_id_q[NUM_STAGES-2:0], c_id_q};
    rsp_valid_d = rsp_fire_c;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    seq_err_d   = seq_err_q | mismatch_c;
    inflight_d  = inflight_q;
    if (rsp_fire_c) begin
      rsp_id_d  = tail_id_c;
      rsp_cos_d = bus.c_cos;
      rsp_sin_d = bus.c_sin;
    end
    // A valid tail retires the op whether it returns or is dropped
    unique case ({accept_c, tail_v_c})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      c_valid_q    <= 1'b0;
      c_id_q       <= 1'b0;
      c_x_q        <= '0;
      c_y_q        <= '0;
      c_z_q        <= '0;
      c_mode_q     <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_cos_q    <= '0;
      rsp_sin_q    <= '0;
      inflight_q   <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      c_valid_q    <= c_valid_d;
      c_id_q       <= c_id_d;
      c_x_q        <= c_x_d;
      c_y_q        <= c_y_d;
      c_z_q        <= c_z_d;
      c_mode_q     <= c_mode_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_sin_q    <= rsp_sin_d;
      inflight_q   <= inflight_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign bus.c_valid_in = c_valid_q;
  assign bus.c_x        = c_x_q;
  assign bus.c_y        = c_y_q;
  assign bus.c_z        = c_z_q;
  assign bus.c_mode     = c_mode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_cos    = rsp_cos_q;
  assign bus.rsp_sin    = rsp_sin_q;
  assign inflight       = inflight_q;
  assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_cordic_pipe_arbiter.sv
// Bench for cordic_pipe_arbiter: fixed-latency core model, a queue-based reference
// of issue/return timing checked every cycle, and directed literal expectations.
module tb_cordic_pipe_arbiter;
  localparam int unsigned N  = 12;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = $clog2(N + 2) + 1;

  logic clk, rst_n, en;
  logic [CW-1:0] inflight;
  logic seq_err;
  logic inject, kill;

  cordic_pipe_arbiter_if #(.WIDTH(W)) bus ();

  cordic_pipe_arbiter #(.NUM_STAGES(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .inflight(inflight), .seq_err(seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] core_cos(input logic [W-1:0] x, input logic [W-1:0] z);
    return W'(x + z);
  endfunction

  function automatic logic [W-1:0] core_sin(input logic [W-1:0] y, input logic [W-1:0] z,
                                             input logic m);
    return W'((y ^ z) + W'(m));
  endfunction

  // Stand-in core: N-cycle pipeline, sharing rst_n, with fault injection hooks
  logic [N-1:0] cp_v;
  logic [W-1:0] cp_c [N];
  logic [W-1:0] cp_s [N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cp_v <= '0;
    else begin
      cp_v    <= {cp_v[N-2:0], bus.c_valid_in};
      cp_c[0] <= core_cos(bus.c_x, bus.c_z);
      cp_s[0] <= core_sin(bus.c_y, bus.c_z, bus.c_mode);
      for (int i = 1; i < N; i++) begin
        cp_c[i] <= cp_c[i-1];
        cp_s[i] <= cp_s[i-1];
      end
    end
  end
  assign bus.c_valid_out = (cp_v[N-1] | inject) & ~kill;
  assign bus.c_cos       = cp_c[N-1];
  assign bus.c_sin       = cp_s[N-1];

  // Reference: each accept must return N+2 cycles later, unless the core dropped it
  typedef struct {
    int           due;
    logic         id;
    logic [W-1:0] cos;
    logic [W-1:0] sin;
    bit           drop;
  } exp_t;
  exp_t q[$];
  int   mc, peak, rsp_cnt, rsp1_cnt;
  logic m_last, m_seq, m_cvi, m_cmode;
  logic [W-1:0] m_cx, m_cy, m_cz;

  always @(negedge clk) begin
    int   eg, cnt;
    logic etail;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      mc = 0; peak = 0; rsp_cnt = 0; rsp1_cnt = 0;
      m_last = 1'b1; m_seq = 1'b0; m_cvi = 1'b0; m_cmode = 1'b0;
      m_cx = '0; m_cy = '0; m_cz = '0;
    end else begin
      eg = 2;
      if (en) begin
        if (bus.req0_valid && bus.req1_valid) eg = m_last ? 0 : 1;
        else if (bus.req0_valid)              eg = 0;
        else if (bus.req1_valid)              eg = 1;
      end
      check("ready0", 32'(bus.req0_ready), 32'(eg == 0));
      check("ready1", 32'(bus.req1_ready), 32'(eg == 1));
      check("c_valid_in", 32'(bus.c_valid_in), 32'(m_cvi));
      check("c_x", 32'(bus.c_x), 32'(m_cx));
      check("c_y", 32'(bus.c_y), 32'(m_cy));
      check("c_z", 32'(bus.c_z), 32'(m_cz));
      check("c_mode", 32'(bus.c_mode), 32'(m_cmode));
      cnt = 0;
      foreach (q[i]) if (q[i].due > mc) cnt++;
      check("inflight", 32'(inflight), 32'(cnt));
      if (int'(inflight) > peak) peak = int'(inflight);
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (bus.rsp_id) rsp1_cnt++;
      end
      if (q.size() > 0 && q[0].due == mc) begin
        e = q.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(!e.drop));
        if (!e.drop) begin
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_cos", 32'(bus.rsp_cos), 32'(e.cos));
          check("rsp_sin", 32'(bus.rsp_sin), 32'(e.sin));
        end
      end else begin
        check("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
      end
      check("seq_err", 32'(seq_err), 32'(m_seq));
      etail = (q.size() > 0) && (q[0].due == mc + 1);
      if (bus.c_valid_out != etail) m_seq = 1'b1;
      if (etail && !bus.c_valid_out) begin
        e = q.pop_front();
        e.drop = 1'b1;
        q.push_front(e);
      end
      m_cvi = (eg != 2);
      if (eg == 0) begin
        m_cx = bus.req0_x; m_cy = bus.req0_y; m_cz = bus.req0_z; m_cmode = bus.req0_mode;
      end else if (eg == 1) begin
        m_cx = bus.req1_x; m_cy = bus.req1_y; m_cz = bus.req1_z; m_cmode = bus.req1_mode;
      end
      if (eg != 2) begin
        e.due  = mc + int'(N) + 2;
        e.id   = (eg == 1);
        e.cos  = core_cos(m_cx, m_cz);
        e.sin  = core_sin(m_cy, m_cz, m_cmode);
        e.drop = 1'b0;
        q.push_back(e);
        m_last = (eg == 1);
      end
      mc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_z = '0; bus.req0_mode = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_z = '0; bus.req1_mode = 1'b0;
    inject = 1'b0; kill = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int grant_code();
    return bus.req0_ready ? 0 : (bus.req1_ready ? 1 : 2);
  endfunction

  int exp_g2 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int exp_g4 [8] = '{0, 1, 0, 2, 2, 2, 1, 0};
  int exp_v4 [8] = '{0, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("rst_c_valid_in", 32'(bus.c_valid_in), 32'(0));
    check("rst_c_z", 32'(bus.c_z), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_cos", 32'(bus.rsp_cos), 32'(0));
    check("rst_inflight", 32'(inflight), 32'(0));
    check("rst_seq_err", 32'(seq_err), 32'(0));

    // Single req0 op: latency and occupancy
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      bus.req0_valid = (c == 0);
      bus.req0_x = 16'h4DBA; bus.req0_y = 16'h0000; bus.req0_z = 16'h2000; bus.req0_mode = 1'b0;
      @(negedge clk);
      if (c == 0) check("t1_ready0", 32'(bus.req0_ready), 32'(1));
      if (c == 1) begin
        check("t1_civ", 32'(bus.c_valid_in), 32'(1));
        check("t1_cz", 32'(bus.c_z), 32'h2000);
        check("t1_inflight1", 32'(inflight), 32'(1));
      end
      if (c == 13) begin
        check("t1_inflight13", 32'(inflight), 32'(1));
        check("t1_rsp_early", 32'(bus.rsp_valid), 32'(0));
      end
      if (c == 14) begin
        check("t1_rsp", 32'(bus.rsp_valid), 32'(1));
        check("t1_rsp_id", 32'(bus.rsp_id), 32'(0));
        check("t1_rsp_cos", 32'(bus.rsp_cos), 32'h6DBA);
        check("t1_inflight14", 32'(inflight), 32'(0));
      end
      step();
    end

    // Both requesters for 8 cycles: strict alternation
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.req0_valid = 1'b1; bus.req0_x = W'(16'h0100 + c); bus.req0_y = W'(c); bus.req0_z = W'(16'h1000 + c);
      bus.req1_valid = 1'b1; bus.req1_x = W'(16'h0200 + c); bus.req1_y = W'(16'h55 + c);
      bus.req1_z = W'(16'h3000 + c); bus.req1_mode = 1'b1;
      @(negedge clk);
      check("t2_grant", 32'(grant_code()), 32'(exp_g2[c]));
      step();
    end
    idle_inputs();
    repeat (20) step();
    check("t2_peak", 32'(peak), 32'(8));
    check("t2_rsp_cnt", 32'(rsp_cnt), 32'(8));

    // req1 alone over a 360-entry angle table
    do_reset();
    for (int i = 0; i < 360; i++) begin
      bus.req1_valid = 1'b1; bus.req1_x = 16'h4DBA; bus.req1_y = W'(i);
      bus.req1_z = W'(i * 182); bus.req1_mode = i[0];
      step();
    end
    idle_inputs();
    repeat (20) step();
    check("t3_rsp1_cnt", 32'(rsp1_cnt), 32'(360));
    check("t3_seq_err", 32'(seq_err), 32'(0));

    // en low for cycles 3..5 with both requesters valid
    do_reset();
    for (int c = 0; c < 8; c++) begin
      en = !(c >= 3 && c <= 5);
      bus.req0_valid = 1'b1; bus.req0_z = W'(16'h0A00 + c);
      bus.req1_valid = 1'b1; bus.req1_z = W'(16'h0B00 + c);
      @(negedge clk);
      check("t4_grant", 32'(grant_code()), 32'(exp_g4[c]));
      check("t4_civ", 32'(bus.c_valid_in), 32'(exp_v4[c]));
      step();
    end
    en = 1'b1;
    idle_inputs();
    repeat (20) step();
    check("t4_rsp_cnt", 32'(rsp_cnt), 32'(5));

    // Spurious core valid_out with nothing in flight
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      inject = (c == 2);
      @(negedge clk);
      if (c == 2) check("t5_seq_pre", 32'(seq_err), 32'(0));
      if (c == 3) begin
        check("t5_seq_set", 32'(seq_err), 32'(1));
        check("t5_no_rsp", 32'(bus.rsp_valid), 32'(0));
      end
      if (c == 20) check("t5_seq_sticky", 32'(seq_err), 32'(1));
      step();
    end
    rst_n = 1'b0;
    #1 check("t5_seq_clr", 32'(seq_err), 32'(0));

    // Core drops a valid result
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      bus.req0_valid = (c == 0); bus.req0_z = 16'h0777;
      kill = (c == 13);
      @(negedge clk);
      if (c == 14) begin
        check("t6_no_rsp", 32'(bus.rsp_valid), 32'(0));
        check("t6_seq", 32'(seq_err), 32'(1));
        check("t6_inflight", 32'(inflight), 32'(0));
      end
      step();
    end

    // Asynchronous reset with five ops in flight
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req0_valid = 1'b1; bus.req0_x = W'(16'h0F00 + c); bus.req0_z = W'(16'h0100 + c);
      step();
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("t7_civ", 32'(bus.c_valid_in), 32'(0));
    check("t7_cx", 32'(bus.c_x), 32'(0));
    check("t7_inflight", 32'(inflight), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step();
    check("t7_no_rsp", 32'(rsp_cnt), 32'(0));
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    check("t7_tie0", 32'(bus.req0_ready), 32'(1));
    check("t7_tie1", 32'(bus.req1_ready), 32'(0));
    step();
    idle_inputs();
    repeat (16) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
